// File: rtl/match_referee.sv
// match_referee: round and match controller for a two-player fighting game.
// Watches the health bits of both player FSMs, judges knockouts and round
// timeouts, keeps round-win scores and declares the match winner.
//
// Optional feature macro: REFEREE_TIMEOUT_EN
//   defined   : round timer counts down and a timer of 0 ends the round,
//               judged on remaining health.
//   undefined : timer is held at 0 and rounds end only by knockout.
//
// Control: start is a plain level, sampled every cycle; it is acted on only
// in IDLE and MATCH_OVER and there is no valid/ready handshake on any port.
// dbg_state mirrors the FSM state for observation (0 IDLE, 1 FIGHT,
// 2 ROUND_END, 3 MATCH_OVER).
module match_referee #(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TICKS   = 200,
  parameter int TIMER_W       = 8,
  parameter int END_HOLD      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         p1_state,
  input  logic [3:0]         p2_state,
  output logic               round_active,
  output logic               round_restart,
  output logic [TIMER_W-1:0] timer,
  output logic [1:0]         p1_wins,
  output logic [1:0]         p2_wins,
  output logic [1:0]         round_result,
  output logic [1:0]         winner,
  output logic               match_over,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FIGHT      = 2'd1,
    S_ROUND_END  = 2'd2,
    S_MATCH_OVER = 2'd3
  } state_t;

  // Outcome / winner encodings shared by round_result and winner.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [3:0] HOLD_LAST  = 4'(END_HOLD - 1);
  localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);

`ifdef REFEREE_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TICKS_LOAD = TIMER_W'(ROUND_TICKS);
`else
  // Without timeouts the timer is pinned to zero; ROUND_TICKS is kept only so
  // both builds share one parameter list.
  localparam logic [TIMER_W-1:0] TICKS_LOAD = '0;
  localparam int UNUSED_ROUND_TICKS = ROUND_TICKS;
`endif

  // Parameter range guards, checked at elaboration.
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 3) begin : g_bad_rounds
    $error("match_referee: ROUNDS_TO_WIN must be 1..3");
  end
  if (END_HOLD < 1 || END_HOLD > 15) begin : g_bad_hold
    $error("match_referee: END_HOLD must be 1..15");
  end
  if (ROUND_TICKS < 1 || ROUND_TICKS > (2 ** TIMER_W) - 1) begin : g_bad_ticks
    $error("match_referee: ROUND_TICKS out of range for TIMER_W");
  end

  state_t     state;
  logic [3:0] hold_cnt;

  // Place bits are carried by the player encoding but play no part in judging.
  logic       unused_place;
  assign unused_place = ^{p1_state[3:2], p2_state[3:2]};

  logic [1:0] hp1, hp2;
  logic       ko1, ko2, timeout;
  logic [1:0] outcome;

  assign hp1 = p1_state[1:0];
  assign hp2 = p2_state[1:0];
  assign ko1 = (hp1 == 2'd0);
  assign ko2 = (hp2 == 2'd0);

`ifdef REFEREE_TIMEOUT_EN
  assign timeout = (timer == '0);
`else
  assign timeout = 1'b0;
`endif

  assign dbg_state = state;

  // Judge the current FIGHT cycle: knockouts take priority over a timeout.
  always_comb begin
    outcome = RES_NONE;
    if (ko1 && ko2) begin
      outcome = RES_DRAW;
    end else if (ko2) begin
      outcome = RES_P1;
    end else if (ko1) begin
      outcome = RES_P2;
    end else if (timeout) begin
      if (hp1 > hp2) begin
        outcome = RES_P1;
      end else if (hp1 < hp2) begin
        outcome = RES_P2;
      end else begin
        outcome = RES_DRAW;
      end
    end
  end

  // Score increment that stops at 3 instead of wrapping.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  // Referee FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      p1_wins       <= 2'd0;
      p2_wins       <= 2'd0;
      round_result  <= RES_NONE;
      winner        <= RES_NONE;
      hold_cnt      <= 4'd0;
      round_active  <= 1'b0;
      round_restart <= 1'b1;
      match_over    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            timer         <= TICKS_LOAD;
            p1_wins       <= 2'd0;
            p2_wins       <= 2'd0;
            state         <= S_FIGHT;
            round_active  <= 1'b1;
            round_restart <= 1'b0;
          end
        end

        S_FIGHT: begin
          if (outcome != RES_NONE) begin
            round_result <= outcome;
            if (outcome == RES_P1) begin
              p1_wins <= sat_inc(p1_wins);
            end
            if (outcome == RES_P2) begin
              p2_wins <= sat_inc(p2_wins);
            end
            hold_cnt      <= 4'd0;
            state         <= S_ROUND_END;
            round_active  <= 1'b0;
            round_restart <= 1'b1;
          end else begin
`ifdef REFEREE_TIMEOUT_EN
            // Reaching here implies timer != 0, so this never wraps.
            timer <= timer - 1'b1;
`else
            timer <= '0;
`endif
          end
        end

        S_ROUND_END: begin
          hold_cnt <= hold_cnt + 4'd1;
          if (hold_cnt == HOLD_LAST) begin
            if (p1_wins == WIN_TARGET || p2_wins == WIN_TARGET) begin
              winner        <= (p1_wins == WIN_TARGET) ? RES_P1 : RES_P2;
              state         <= S_MATCH_OVER;
              match_over    <= 1'b1;
              round_restart <= 1'b0;
            end else begin
              timer         <= TICKS_LOAD;
              state         <= S_FIGHT;
              round_active  <= 1'b1;
              round_restart <= 1'b0;
            end
          end
        end

        S_MATCH_OVER: begin
          // Results stay frozen until a new match is requested; the restart
          // passes through ROUND_END so the players are reset first.
          if (start) begin
            p1_wins       <= 2'd0;
            p2_wins       <= 2'd0;
            winner        <= RES_NONE;
            round_result  <= RES_NONE;
            hold_cnt      <= 4'd0;
            state         <= S_ROUND_END;
            match_over    <= 1'b0;
            round_restart <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_referee.sv
// Directed testbench for match_referee with default parameters.
module tb_match_referee;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] p1_state, p2_state;
  logic       round_active, round_restart, match_over;
  logic [7:0] timer;
  logic [1:0] p1_wins, p2_wins, round_result, winner, dbg_state;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIGHT = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

`ifdef REFEREE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [7:0] EXP_LOAD = TO_EN ? 8'd200 : 8'd0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_r;

  match_referee dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p1_state     (p1_state),
    .p2_state     (p2_state),
    .round_active (round_active),
    .round_restart(round_restart),
    .timer        (timer),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .round_result (round_result),
    .winner       (winner),
    .match_over   (match_over),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Advance n full cycles; inputs are driven and outputs sampled on negedge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] target, input int bound, output int cycles);
    cycles = 0;
    while (dbg_state !== target && cycles < bound) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; p1_state = 4'b0111; p2_state = 4'b1011;
    tick(2);
    n_cmp++;
    if (round_restart !== 1'b1) begin
      n_fail++; $display("FAIL reset_restart: got %0b want 1", round_restart);
    end
    n_cmp++;
    if ({round_active, timer, p1_wins, p2_wins, round_result, winner, match_over} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got act=%0b tmr=%0d p1=%0d p2=%0d res=%0b win=%0b mo=%0b want all 0",
               round_active, timer, p1_wins, p2_wins, round_result, winner, match_over);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL idle_hold: got %0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_p1_ko;
    int cnt;
    logic [7:0] exp_t;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++;
    if ({dbg_state, round_active, round_restart} !== {ST_FIGHT, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ko_enter_fight: got st=%0d act=%0b rst=%0b want 1 1 0",
                         dbg_state, round_active, round_restart);
    end
    n_cmp++;
    if (timer !== EXP_LOAD) begin
      n_fail++; $display("FAIL ko_timer_load: got %0d want %0d", timer, EXP_LOAD);
    end
    tick(2);
    exp_t = TO_EN ? 8'd198 : 8'd0;
    n_cmp++;
    if (timer !== exp_t) begin
      n_fail++; $display("FAIL ko_timer_count: got %0d want %0d", timer, exp_t);
    end
    p2_state = 4'b1100;
    exp_q.push_back(2'b01);
    tick(1);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({dbg_state, p1_wins, p2_wins, round_result} !== {ST_END, 2'd1, 2'd0, exp_r}) begin
      n_fail++; $display("FAIL ko_result: got st=%0d p1=%0d p2=%0d res=%0b want 2 1 0 %0b",
                         dbg_state, p1_wins, p2_wins, round_result, exp_r);
    end
    n_cmp++;
    if ({round_active, round_restart} !== 2'b01) begin
      n_fail++; $display("FAIL ko_gating: got act=%0b rst=%0b want 0 1", round_active, round_restart);
    end
    p2_state = 4'b1011;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (round_restart !== 1'b1) break;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 4) begin
      n_fail++; $display("FAIL ko_hold_len: got %0d want 4", cnt);
    end
    n_cmp++;
    if ({dbg_state, round_active, timer} !== {ST_FIGHT, 1'b1, EXP_LOAD}) begin
      n_fail++; $display("FAIL ko_resume: got st=%0d act=%0b tmr=%0d want 1 1 %0d",
                         dbg_state, round_active, timer, EXP_LOAD);
    end
  endtask

  task automatic test_draw;
    int c;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++;
    if (dbg_state !== ST_FIGHT) begin
      n_fail++; $display("FAIL start_in_fight: got %0d want %0d", dbg_state, ST_FIGHT);
    end
    p1_state = 4'b0100;
    p2_state = 4'b1000;
    exp_q.push_back(2'b11);
    tick(1);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({dbg_state, p1_wins, p2_wins, round_result} !== {ST_END, 2'd1, 2'd0, exp_r}) begin
      n_fail++; $display("FAIL draw_result: got st=%0d p1=%0d p2=%0d res=%0b want 2 1 0 %0b",
                         dbg_state, p1_wins, p2_wins, round_result, exp_r);
    end
    p1_state = 4'b0111;
    p2_state = 4'b1011;
    wait_state(ST_FIGHT, 10, c);
    n_cmp++;
    if (dbg_state !== ST_FIGHT) begin
      n_fail++; $display("FAIL draw_resume: got %0d want %0d", dbg_state, ST_FIGHT);
    end
  endtask

  task automatic test_match_win;
    int c;
    int cnt;
    p1_state = 4'b0000;
    exp_q.push_back(2'b10);
    tick(1);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({p2_wins, round_result} !== {2'd1, exp_r}) begin
      n_fail++; $display("FAIL win_round1: got p2=%0d res=%0b want 1 %0b", p2_wins, round_result, exp_r);
    end
    p1_state = 4'b0111;
    wait_state(ST_FIGHT, 10, c);
    p1_state = 4'b1100;
    exp_q.push_back(2'b10);
    tick(1);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({p1_wins, p2_wins, round_result} !== {2'd1, 2'd2, exp_r}) begin
      n_fail++; $display("FAIL win_round2: got p1=%0d p2=%0d res=%0b want 1 2 %0b",
                         p1_wins, p2_wins, round_result, exp_r);
    end
    p1_state = 4'b0111;
    tick(3);
    n_cmp++;
    if ({dbg_state, match_over} !== {ST_END, 1'b0}) begin
      n_fail++; $display("FAIL win_hold_last: got st=%0d mo=%0b want 2 0", dbg_state, match_over);
    end
    tick(1);
    n_cmp++;
    if ({dbg_state, match_over, winner, round_restart, round_active} !== {ST_OVER, 1'b1, 2'b10, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL win_declared: got st=%0d mo=%0b win=%0b rst=%0b act=%0b want 3 1 10 0 0",
                         dbg_state, match_over, winner, round_restart, round_active);
    end
    p2_state = 4'b0000;
    tick(3);
    n_cmp++;
    if ({dbg_state, p1_wins, p2_wins, round_result, winner} !== {ST_OVER, 2'd1, 2'd2, 2'b10, 2'b10}) begin
      n_fail++; $display("FAIL win_frozen: got st=%0d p1=%0d p2=%0d res=%0b win=%0b want 3 1 2 10 10",
                         dbg_state, p1_wins, p2_wins, round_result, winner);
    end
    p2_state = 4'b1011;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++;
    if ({dbg_state, p1_wins, p2_wins, round_result, winner, round_restart, match_over} !==
        {ST_END, 2'd0, 2'd0, 2'b00, 2'b00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rematch_clear: got st=%0d p1=%0d p2=%0d res=%0b win=%0b rst=%0b mo=%0b want 2 0 0 0 0 1 0",
                         dbg_state, p1_wins, p2_wins, round_result, winner, round_restart, match_over);
    end
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (round_restart !== 1'b1) break;
      cnt++;
    end
    n_cmp++;
    if ({cnt[3:0], dbg_state, timer} !== {4'd4, ST_FIGHT, EXP_LOAD}) begin
      n_fail++; $display("FAIL rematch_restart: got len=%0d st=%0d tmr=%0d want 4 1 %0d",
                         cnt, dbg_state, timer, EXP_LOAD);
    end
  endtask

  task automatic test_reset_mid_end;
    p2_state = 4'b0000;
    exp_q.push_back(2'b01);
    tick(1);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({p1_wins, round_result} !== {2'd1, exp_r}) begin
      n_fail++; $display("FAIL mid_ko: got p1=%0d res=%0b want 1 %0b", p1_wins, round_result, exp_r);
    end
    p2_state = 4'b1011;
    start = 1'b1;
    tick(1);
    n_cmp++;
    if (dbg_state !== ST_END) begin
      n_fail++; $display("FAIL start_in_end: got %0d want %0d", dbg_state, ST_END);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dbg_state, p1_wins, p2_wins, round_result, round_restart, timer} !==
        {ST_IDLE, 2'd0, 2'd0, 2'b00, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL mid_reset: got st=%0d p1=%0d p2=%0d res=%0b rst=%0b tmr=%0d want 0 0 0 0 1 0",
                         dbg_state, p1_wins, p2_wins, round_result, round_restart, timer);
    end
    start = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL mid_after: got %0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

`ifdef REFEREE_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    int c;
    p1_state = 4'b0011;
    p2_state = 4'b0010;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (dbg_state !== ST_FIGHT) break;
      cnt++;
    end
    exp_q.push_back(2'b01);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({cnt[8:0], p1_wins, round_result} !== {9'd201, 2'd1, exp_r}) begin
      n_fail++; $display("FAIL timeout_round: got len=%0d p1=%0d res=%0b want 201 1 %0b",
                         cnt, p1_wins, round_result, exp_r);
    end
    wait_state(ST_FIGHT, 10, c);
    p1_state = 4'b0010;
    tick(200);
    n_cmp++;
    if ({dbg_state, timer} !== {ST_FIGHT, 8'd0}) begin
      n_fail++; $display("FAIL timeout_zero: got st=%0d tmr=%0d want 1 0", dbg_state, timer);
    end
    p1_state = 4'b0000;
    exp_q.push_back(2'b10);
    tick(1);
    exp_r = exp_q.pop_front();
    n_cmp++;
    if ({p2_wins, round_result} !== {2'd1, exp_r}) begin
      n_fail++; $display("FAIL ko_at_zero: got p2=%0d res=%0b want 1 %0b", p2_wins, round_result, exp_r);
    end
    p1_state = 4'b0111;
    p2_state = 4'b1011;
  endtask
`else
  task automatic test_no_timeout;
    int bad;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (dbg_state !== ST_FIGHT || timer !== 8'd0) bad++;
    end
    n_cmp++;
    if ({bad, dbg_state, timer} !== {32'd0, ST_FIGHT, 8'd0}) begin
      n_fail++; $display("FAIL no_timeout: got bad=%0d st=%0d tmr=%0d want 0 1 0", bad, dbg_state, timer);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_p1_ko();
    test_draw();
    test_match_win();
    test_reset_mid_end();
`ifdef REFEREE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
